// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID build-match checker.
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_WT_ID,
    ST_RD_TS,
    ST_WT_TS,
    ST_DONE
  } sysid_state_e;

  localparam logic SYSID_OFF_ID = 1'b0;
  localparam logic SYSID_OFF_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID = 32'd0;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1382618285;

endpackage

// File: rtl/avalon_read_timer.sv
// Per-transaction cycle limit for the read master; TIMEOUT_CYC=0 disables it.
module avalon_read_timer #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYC == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = clock ^ reset_n ^ clear ^ enable;
    assign expired       = 1'b0;
  end else begin : g_on
    localparam int unsigned    CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count;

    // Count cycles spent in a transaction; saturate at the limit.
    always_ff @(posedge clock) begin
      if (!reset_n || clear) begin
        count <= '0;
      end else if (enable && (count != LAST)) begin
        count <= count + 1'b1;
      end
    end

    assign expired = enable && (count == LAST);
  end

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and
// compares them against build-time values to gate soft-CPU boot.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID       = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS       = SYSID_DEFAULT_TS,
  parameter bit          USE_READDATAVALID = 1'b0,
  parameter int unsigned TIMEOUT_CYC       = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] got_id,
  output logic [31:0] got_ts
);

  sysid_state_e state;

  logic in_rd;
  logic in_wt;
  logic id_phase;
  logic accept;
  logic word_done;
  logic expired;
  logic timer_clear;
  logic timer_enable;

  // Decode handshake events for the current state.
  always_comb begin
    in_rd     = (state == ST_RD_ID) || (state == ST_RD_TS);
    in_wt     = (state == ST_WT_ID) || (state == ST_WT_TS);
    id_phase  = (state == ST_RD_ID) || (state == ST_WT_ID);
    accept    = in_rd && !m_waitrequest;
    word_done = USE_READDATAVALID ? (in_wt && m_readdatavalid) : accept;
  end

  // Timer restarts whenever a new RD_* state is entered (from IDLE/DONE or after the ID word).
  assign timer_enable = in_rd || in_wt;
  assign timer_clear  = !timer_enable || (word_done && id_phase);

  avalon_read_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (expired)
  );

  // Check sequencer with registered bus strobes, status and captured words.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      m_read    <= 1'b0;
      m_address <= SYSID_OFF_ID;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      timeout   <= 1'b0;
      got_id    <= '0;
      got_ts    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start || (state == ST_IDLE)) begin
            pass    <= 1'b0;
            id_ok   <= 1'b0;
            ts_ok   <= 1'b0;
            timeout <= 1'b0;
            got_id  <= '0;
            got_ts  <= '0;
          end
          if (start) begin
            state     <= ST_RD_ID;
            m_read    <= 1'b1;
            m_address <= SYSID_OFF_ID;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end

        ST_RD_ID, ST_WT_ID: begin
          if (word_done) begin
            got_id    <= m_readdata;
            id_ok     <= (m_readdata == EXPECTED_ID);
            state     <= ST_RD_TS;
            m_read    <= 1'b1;
            m_address <= SYSID_OFF_TS;
          end else if (expired) begin
            state   <= ST_DONE;
            timeout <= 1'b1;
            pass    <= 1'b0;
            m_read  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (accept) begin
            state  <= ST_WT_ID;
            m_read <= 1'b0;
          end
        end

        ST_RD_TS, ST_WT_TS: begin
          if (word_done) begin
            got_ts <= m_readdata;
            ts_ok  <= (m_readdata == EXPECTED_TS);
            pass   <= id_ok && (m_readdata == EXPECTED_TS);
            state  <= ST_DONE;
            m_read <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else if (expired) begin
            state   <= ST_DONE;
            timeout <= 1'b1;
            pass    <= 1'b0;
            m_read  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (accept) begin
            state  <= ST_WT_TS;
            m_read <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench: dut0 is a zero-latency (mode 0) checker, dut1 a pipelined
// (mode 1) checker with a short timeout; each faces a behavioural sysid slave.
module tb_sysid_checker;
  import sysid_pkg::*;

  localparam logic [31:0] EXP_ID0 = SYSID_DEFAULT_ID;
  localparam logic [31:0] EXP_TS0 = SYSID_DEFAULT_TS;
  localparam logic [31:0] EXP_ID1 = 32'hC0DE_0042;
  localparam logic [31:0] EXP_TS1 = 32'h1234_5678;
  localparam int          TMO1    = 8;

  typedef struct {
    logic        pass_v;
    logic        id_v;
    logic        ts_v;
    logic        tmo_v;
    logic [31:0] gid;
    logic [31:0] gts;
    int          lat;
    int          t0;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  logic        start   [2];
  logic        wr      [2];
  logic [31:0] rdata   [2];
  logic        rdv     [2];
  logic        m_read  [2];
  logic        m_address[2];
  logic        busy    [2];
  logic        done    [2];
  logic        pass    [2];
  logic        id_ok   [2];
  logic        ts_ok   [2];
  logic        timeout [2];
  logic [31:0] got_id  [2];
  logic [31:0] got_ts  [2];

  // Slave model state
  int          stall_plan[2][2];
  int          lat_plan  [2][2];
  logic [31:0] id_val    [2];
  logic [31:0] ts_val    [2];
  bit          mute      [2];
  bit          stray_req [2];
  bit          in_read   [2];
  int          stall_left[2];
  int          pend_left [2];
  logic [31:0] pend_data [2];
  logic        last_addr [2];
  bit          stalled_prev[2];

  exp_t sb0[$];
  exp_t sb1[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sysid_checker u_dut0 (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start[0]),
    .m_address       (m_address[0]),
    .m_read          (m_read[0]),
    .m_waitrequest   (wr[0]),
    .m_readdata      (rdata[0]),
    .m_readdatavalid (rdv[0]),
    .busy            (busy[0]),
    .done            (done[0]),
    .pass            (pass[0]),
    .id_ok           (id_ok[0]),
    .ts_ok           (ts_ok[0]),
    .timeout         (timeout[0]),
    .got_id          (got_id[0]),
    .got_ts          (got_ts[0])
  );

  sysid_checker #(
    .EXPECTED_ID       (EXP_ID1),
    .EXPECTED_TS       (EXP_TS1),
    .USE_READDATAVALID (1'b1),
    .TIMEOUT_CYC       (TMO1)
  ) u_dut1 (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start[1]),
    .m_address       (m_address[1]),
    .m_read          (m_read[1]),
    .m_waitrequest   (wr[1]),
    .m_readdata      (rdata[1]),
    .m_readdatavalid (rdv[1]),
    .busy            (busy[1]),
    .done            (done[1]),
    .pass            (pass[1]),
    .id_ok           (id_ok[1]),
    .ts_ok           (ts_ok[1]),
    .timeout         (timeout[1]),
    .got_id          (got_id[1]),
    .got_ts          (got_ts[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_idle(input int k, input string tag);
    check($sformatf("%s_dut%0d_m_read", tag, k), m_read[k], 0);
    check($sformatf("%s_dut%0d_m_address", tag, k), m_address[k], 0);
    check($sformatf("%s_dut%0d_busy", tag, k), busy[k], 0);
    check($sformatf("%s_dut%0d_done", tag, k), done[k], 0);
    check($sformatf("%s_dut%0d_pass", tag, k), pass[k], 0);
    check($sformatf("%s_dut%0d_id_ok", tag, k), id_ok[k], 0);
    check($sformatf("%s_dut%0d_ts_ok", tag, k), ts_ok[k], 0);
    check($sformatf("%s_dut%0d_timeout", tag, k), timeout[k], 0);
    check($sformatf("%s_dut%0d_got_id", tag, k), got_id[k], 0);
    check($sformatf("%s_dut%0d_got_ts", tag, k), got_ts[k], 0);
  endtask

  // Reference model: outcome and start-to-done latency from the slave plan.
  function automatic exp_t model(input int k, input logic [31:0] idv, input logic [31:0] tsv,
                                 input int s_id, input int l_id, input int s_ts, input int l_ts,
                                 input bit mt);
    exp_t e;
    logic [31:0] eid;
    logic [31:0] ets;
    eid = (k == 1) ? EXP_ID1 : EXP_ID0;
    ets = (k == 1) ? EXP_TS1 : EXP_TS0;
    e.t0 = 0;
    if (mt) begin
      e.pass_v = 0; e.id_v = 0; e.ts_v = 0; e.tmo_v = 1;
      e.gid = 0; e.gts = 0; e.lat = TMO1;
    end else begin
      e.gid    = idv;
      e.gts    = tsv;
      e.id_v   = (idv == eid);
      e.ts_v   = (tsv == ets);
      e.pass_v = e.id_v && e.ts_v;
      e.tmo_v  = 0;
      e.lat    = 2 + s_id + s_ts + ((k == 1) ? (l_id + l_ts) : 0);
    end
    return e;
  endfunction

  // Behavioural sysid slaves: planned waitrequest stalls, readdatavalid latency.
  initial begin
    for (int k = 0; k < 2; k++) begin
      wr[k] = 0; rdv[k] = 0; rdata[k] = '0; pend_left[k] = 0; in_read[k] = 0;
      stalled_prev[k] = 0; stray_req[k] = 0; mute[k] = 0; id_val[k] = '0; ts_val[k] = '0;
      for (int a = 0; a < 2; a++) begin stall_plan[k][a] = 0; lat_plan[k][a] = 0; end
    end
    forever begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        if (stalled_prev[k]) begin
          check($sformatf("stall_read_dut%0d", k), m_read[k], 1);
          check($sformatf("stall_addr_dut%0d", k), m_address[k], last_addr[k]);
        end
        rdv[k] = 0;
        if (k == 0) rdata[k] = m_address[0] ? ts_val[0] : id_val[0];
        else        rdata[k] = $urandom;
        if (pend_left[k] > 0) begin
          pend_left[k]--;
          if (pend_left[k] == 0 && !mute[k]) begin
            rdv[k]   = 1;
            rdata[k] = pend_data[k];
          end
        end
        if (stray_req[k]) begin
          rdv[k]       = 1;
          rdata[k]     = 32'hBAD0_5EED;
          stray_req[k] = 0;
        end
        stalled_prev[k] = 0;
        if (m_read[k]) begin
          if (!in_read[k]) begin
            in_read[k]    = 1;
            stall_left[k] = stall_plan[k][int'(m_address[k])];
          end
          if (stall_left[k] > 0) begin
            wr[k] = 1;
            stall_left[k]--;
            stalled_prev[k] = 1;
            last_addr[k]    = m_address[k];
          end else begin
            wr[k]        = 0;
            in_read[k]   = 0;
            pend_left[k] = lat_plan[k][int'(m_address[k])];
            pend_data[k] = m_address[k] ? ts_val[k] : id_val[k];
          end
        end else begin
          wr[k]      = 0;
          in_read[k] = 0;
        end
      end
    end
  end

  // Monitor: on each rising done, pop the expected result and compare.
  initial begin
    bit   prev[2];
    exp_t e;
    bit   have;
    prev[0] = 0; prev[1] = 0;
    forever begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        if (done[k] && !prev[k]) begin
          have = 0;
          if (k == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1; end
          if (k == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1; end
          if (!have) begin
            checks++; failures++;
            $display("FAIL unexpected_done dut%0d actual=1 required=0", k);
          end else begin
            check($sformatf("pass_dut%0d", k), pass[k], e.pass_v);
            check($sformatf("id_ok_dut%0d", k), id_ok[k], e.id_v);
            check($sformatf("ts_ok_dut%0d", k), ts_ok[k], e.ts_v);
            check($sformatf("timeout_dut%0d", k), timeout[k], e.tmo_v);
            check($sformatf("got_id_dut%0d", k), got_id[k], e.gid);
            check($sformatf("got_ts_dut%0d", k), got_ts[k], e.gts);
            check($sformatf("latency_dut%0d", k), cyc - e.t0, e.lat);
            check($sformatf("done_m_read_dut%0d", k), m_read[k], 0);
            check($sformatf("done_busy_dut%0d", k), busy[k], 0);
          end
        end
        prev[k] = done[k];
      end
    end
  end

  task automatic run(input int k, input logic [31:0] idv, input logic [31:0] tsv,
                     input int s_id, input int l_id, input int s_ts, input int l_ts,
                     input bit mt, input bit poke);
    exp_t e;
    int   n;
    @(negedge clock);
    id_val[k] = idv; ts_val[k] = tsv; mute[k] = mt;
    stall_plan[k][0] = s_id; lat_plan[k][0] = l_id;
    stall_plan[k][1] = s_ts; lat_plan[k][1] = l_ts;
    e    = model(k, idv, tsv, s_id, l_id, s_ts, l_ts, mt);
    e.t0 = cyc + 1;
    if (k == 0) sb0.push_back(e); else sb1.push_back(e);
    start[k] = 1;
    @(negedge clock);
    start[k] = 0;
    check($sformatf("start_busy_dut%0d", k), busy[k], 1);
    check($sformatf("start_done_dut%0d", k), done[k], 0);
    check($sformatf("start_m_read_dut%0d", k), m_read[k], 1);
    check($sformatf("start_m_address_dut%0d", k), m_address[k], 0);
    check($sformatf("start_clear_dut%0d", k),
          {pass[k], id_ok[k], ts_ok[k], timeout[k], (got_id[k] != 0), (got_ts[k] != 0)}, 0);
    if (poke) begin
      start[k] = 1;
      @(negedge clock);
      start[k] = 0;
    end
    n = 0;
    while (n < 60 && ((k == 0) ? sb0.size() : sb1.size()) > 0) begin
      @(negedge clock);
      n++;
    end
    if (((k == 0) ? sb0.size() : sb1.size()) > 0) begin
      checks++; failures++;
      $display("FAIL done_wait_dut%0d actual=no_done required=done", k);
      if (k == 0) sb0.delete(); else sb1.delete();
    end
    mute[k] = 0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ev_id, ev_ts, idv, tsv;
    int          k;
    bit          found;
    start[0] = 0; start[1] = 0;
    reset_n  = 0;
    repeat (3) @(negedge clock);
    check_idle(0, "reset");
    check_idle(1, "reset");
    reset_n = 1;
    @(negedge clock);

    // Mode 0 directed: matching words, then a one-off timestamp.
    run(0, EXP_ID0, EXP_TS0, 0, 0, 0, 0, 0, 0);
    run(0, EXP_ID0, 32'd1382618284, 0, 0, 0, 0, 0, 0);

    // Stray beat while idle must not be captured.
    @(negedge clock);
    stray_req[1] = 1;
    repeat (3) @(negedge clock);
    check("stray_idle_got_id", got_id[1], 0);
    check("stray_idle_done", done[1], 0);
    check("stray_idle_busy", busy[1], 0);

    // Mode 1 directed: 3-cycle stall on ID, data two cycles after accept.
    run(1, EXP_ID1, EXP_TS1, 3, 2, 0, 1, 0, 0);
    // Mode 1 timeout: readdatavalid never arrives.
    run(1, EXP_ID1, EXP_TS1, 0, 1, 0, 1, 1, 0);
    // Start pulsed while busy is ignored; start in DONE reruns.
    run(0, EXP_ID0, EXP_TS0, 0, 0, 0, 0, 0, 1);
    run(1, EXP_ID1, EXP_TS1 ^ 32'h10, 1, 1, 1, 2, 0, 1);

    // Randomized runs on both checkers.
    for (int n = 0; n < 24; n++) begin
      k     = n % 2;
      ev_id = (k == 1) ? EXP_ID1 : EXP_ID0;
      ev_ts = (k == 1) ? EXP_TS1 : EXP_TS0;
      idv   = ($urandom_range(0, 2) != 0) ? ev_id : (ev_id ^ (32'd1 << $urandom_range(0, 31)));
      tsv   = ($urandom_range(0, 2) != 0) ? ev_ts : (ev_ts ^ (32'd1 << $urandom_range(0, 31)));
      if (k == 0)
        run(0, idv, tsv, $urandom_range(0, 3), 0, $urandom_range(0, 3), 0, 0, n[2]);
      else
        run(1, idv, tsv, $urandom_range(0, 3), $urandom_range(1, 2),
            $urandom_range(0, 3), $urandom_range(1, 2), 0, n[2]);
    end

    // Reset during WT_TS, late beat ignored, then a fresh passing check.
    @(negedge clock);
    id_val[1] = EXP_ID1; ts_val[1] = EXP_TS1;
    stall_plan[1][0] = 0; lat_plan[1][0] = 1;
    stall_plan[1][1] = 0; lat_plan[1][1] = 4;
    start[1] = 1;
    @(negedge clock);
    start[1] = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (busy[1] && !m_read[1] && m_address[1]) found = 1;
    end
    check("reach_wt_ts", found, 1);
    reset_n = 0;
    @(negedge clock);
    reset_n = 1;
    check_idle(1, "rst_mid");
    check_idle(0, "rst_mid");
    repeat (6) @(negedge clock);
    check("post_rst_got_ts", got_ts[1], 0);
    check("post_rst_done", done[1], 0);
    check("post_rst_busy", busy[1], 0);
    run(1, EXP_ID1, EXP_TS1, 0, 1, 0, 1, 0, 0);
    run(0, EXP_ID0, EXP_TS0, 1, 0, 2, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Avalon-MM read master that interrogates a system-ID slave after reset or on request. It reads the ID word (offset 0) and the timestamp word (offset 1), compares both against build-time expected values, and reports pass, fail or timeout. It sits beside the soft-CPU boot logic and gates boot on a hardware/software build match. It connects directly to a sysid-style control slave, or through the interconnect.

## Interface
Parameters:
- EXPECTED_ID, 32'd0: required value at offset 0.
- EXPECTED_TS, 32'd1382618285: required value at offset 1.
- USE_READDATAVALID, 0:
  - 0: data is sampled on the accept edge. Use this for a fixed zero-latency slave.
  - 1: pipelined read; data arrives with `m_readdatavalid`.
- TIMEOUT_CYC, 256: per-transaction cycle limit. 0 disables the timeout.

Ports:
- clock  in  1  single clock domain.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to run a check.
- m_address  out  1  word offset (0 = ID, 1 = timestamp).
- m_read  out  1  read strobe, registered.
- m_waitrequest  in  1  slave stall. Tie to 0 for zero-wait slaves.
- m_readdata  in  32  read data.
- m_readdatavalid  in  1  read data valid. Used only when USE_READDATAVALID=1.
- busy  out  1  high while a check is in progress.
- done  out  1  level; high while in DONE.
- pass  out  1  equals id_ok & ts_ok & ~timeout. Meaningful only while done=1.
- id_ok, ts_ok  out  1 each  per-word compare results.
- timeout  out  1  a transaction exceeded TIMEOUT_CYC.
- got_id, got_ts  out  32 each  captured words, for debug and mismatch reporting.

## Operation
- States: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, DONE.
- IDLE:
  - start=1 → RD_ID.
  - Clears id_ok, ts_ok, timeout, got_id and got_ts.
- RD_ID: m_read=1, m_address=0. Accept occurs when m_waitrequest=0.
  - USE_READDATAVALID=0: capture m_readdata into got_id on the accept edge, then → RD_TS.
  - USE_READDATAVALID=1: → WT_ID on accept.
- WT_ID: m_read=0. On m_readdatavalid, capture got_id, then → RD_TS.
- RD_TS / WT_TS: same as RD_ID / WT_ID with m_address=1; capture into got_ts, then → DONE.
- Compares: id_ok and ts_ok are registered on their capture edges as full 32-bit equality.
- DONE:
  - Outputs hold.
  - start=1 → RD_ID, clearing all results on that edge (restart).
- start during busy is ignored.
- m_readdatavalid is ignored in IDLE, DONE, and in RD_* states (a stray beat is not data).
- Timeout:
  - The counter clears on entry to each RD_* state and increments every cycle in RD_* and WT_*.
  - If it reaches TIMEOUT_CYC-1 with no completion in that cycle → DONE with timeout=1.
  - The pending word's ok flag stays 0, and m_read drops.
- Completion and timeout expiring in the same cycle: completion wins and timeout stays 0.

## Timing
- Reset values: m_read=0, m_address=0, busy=0, done=0, pass=0, id_ok=0, ts_ok=0, timeout=0, got_id=0, got_ts=0. State is IDLE.
- Mode 0, waitrequest=0, start sampled at edge E0:
  - read of offset 0 is visible after E0;
  - read of offset 1 is visible after E1;
  - done=1 after E2.
- Mode 1, zero waitrequest, readdatavalid one cycle after accept: done=1 after E4.
- Each waitrequest cycle adds one cycle. m_read and m_address stay stable while m_waitrequest=1.
- busy is high from the cycle after the start edge through the last WT/RD cycle. It is 0 in DONE.
- Reset mid-operation: the reset edge returns all outputs to reset values. m_read is low in the next cycle. A later readdatavalid beat is ignored.

## Structure
- Package sysid_pkg holds:
  - the state enum;
  - SYSID_OFF_ID=0 and SYSID_OFF_TS=1;
  - default EXPECTED_ID and EXPECTED_TS constants.
- One sub-module, avalon_read_timer:
  - inputs: clear, enable;
  - outputs: expired.
  - TIMEOUT_CYC=0 disables it: expired is tied to 0.
- The FSM, capture registers and compares stay in sysid_checker.

## Test plan
- Mode 0, slave returns 0 at offset 0 and 1382618285 at offset 1, start pulse → done=1 after E2, pass=1, id_ok=ts_ok=1.
- Mode 0, offset 1 returns 1382618284 → done=1, pass=0, ts_ok=0, got_ts=1382618284.
- Mode 1, waitrequest held 3 cycles on the ID read, readdatavalid 2 cycles after accept → m_address and m_read stable during the stall, got_id captured, pass=1. Also inject a stray readdatavalid in IDLE → no capture.
- Mode 1, TIMEOUT_CYC=8, readdatavalid never asserted → done after 8 cycles in RD_ID+WT_ID, timeout=1, pass=0, m_read=0.
- Reset_n low during WT_TS, then start again → all outputs 0 on the cycle after reset, and a fresh check passes.
- start pulsed while busy → ignored. start in DONE → results clear and the check reruns.
